// File: rtl/series_accumulator.sv
// series_accumulator: evaluates one of four series over k = 1..n one term per clock, then converts the result to BCD/7-seg.
module series_accumulator #(
  parameter int N_W      = 8,
  parameter int ACC_W    = 20,
  parameter int DIGITS   = 7,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [N_W-1:0]        n_in,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [ACC_W-1:0]      result,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg
);
  localparam int W    = ACC_W + 2*N_W;
  localparam int SH_W = 4*DIGITS + ACC_W;
  localparam int CW   = $clog2(ACC_W + 1);
  typedef enum logic [1:0] {IDLE, CALC, CONV, DONE} state_t;
  state_t           st;
  logic [N_W-1:0]   n_r, k;
  logic [1:0]       m_r;
  logic [ACC_W-1:0] acc;
  logic             ovf_int, ovf, seen;
  logic [SH_W-1:0]  sh, adj, shl;
  logic [CW-1:0]    cnt;
  logic [W-1:0]     acc_w, k_w, nxt;
  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0:    dec = 7'b0000001;
      4'd1:    dec = 7'b1001111;
      4'd2:    dec = 7'b0010010;
      4'd3:    dec = 7'b0000110;
      4'd4:    dec = 7'b1001100;
      4'd5:    dec = 7'b0100100;
      4'd6:    dec = 7'b0100000;
      4'd7:    dec = 7'b0001111;
      4'd8:    dec = 7'b0000000;
      4'd9:    dec = 7'b0000100;
      default: dec = 7'b1111111;
    endcase
  endfunction
  // Wide intermediate so the overflowing term is detected rather than wrapped.
  always_comb begin
    acc_w = W'(acc);
    k_w   = W'(k);
    nxt   = m_r == 2'd0 ? acc_w + k_w :
            m_r == 2'd1 ? acc_w + k_w * k_w :
            m_r == 2'd2 ? acc_w + (k_w << 1) - W'(1) :
                          acc_w * k_w;
    ovf   = |nxt[W-1:ACC_W];
  end
  always_comb begin
    adj = sh;
    for (int i = 0; i < DIGITS; i++)
      if (sh[ACC_W+4*i +: 4] >= 4'd5) adj[ACC_W+4*i +: 4] = sh[ACC_W+4*i +: 4] + 4'd3;
    shl = {adj[SH_W-2:0], 1'b0};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      n_r      <= '0;
      m_r      <= '0;
      acc      <= '0;
      k        <= '0;
      ovf_int  <= 1'b0;
      sh       <= '0;
      cnt      <= '0;
      result   <= '0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      case (st)
        IDLE: if (start) begin
          n_r     <= n_in;
          m_r     <= mode;
          acc     <= ACC_W'(mode == 2'd3);
          k       <= N_W'(1);
          cnt     <= '0;
          ovf_int <= 1'b0;
          sh      <= SH_W'(mode == 2'd3);
          st      <= n_in != '0 ? CALC : CONV;
        end
        // The shifter is preloaded every term so CONV can start on the very next edge.
        CALC: begin
          acc     <= nxt[ACC_W-1:0];
          ovf_int <= ovf;
          sh      <= SH_W'(ovf ? {ACC_W{1'b1}} : nxt[ACC_W-1:0]);
          k       <= k + N_W'(1);
          if (ovf || k == n_r) st <= CONV;
        end
        CONV: begin
          sh  <= shl;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(ACC_W - 1)) begin
            st       <= DONE;
            result   <= ovf_int ? {ACC_W{1'b1}} : acc;
            bcd      <= shl[SH_W-1:ACC_W];
            overflow <= ovf_int;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
  assign busy = st == CALC || st == CONV;
  assign done = st == DONE;
  // Scan from the top digit so everything above the first nonzero digit blanks.
  always_comb begin
    seen = 1'b0;
    seg  = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen = seen | (|bcd[4*i +: 4]) | (i == 0) | (BLANK_LZ == 0);
      seg[7*i +: 7] = overflow ? 7'b1111110 : seen ? dec(bcd[4*i +: 4]) : 7'b1111111;
    end
  end
endmodule

// File: tb/tb_series_accumulator.sv
// tb_series_accumulator: directed table-driven checks of series_accumulator plus interference and mid-run reset sequences.
module tb_series_accumulator;
  localparam int N_W = 8, ACC_W = 20, DIGITS = 7, NV = 12;
  localparam logic [6:0] CODE [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                       7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [1:0] mode = '0;
  logic [N_W-1:0] n_in = '0;
  logic busy, done, overflow;
  logic [ACC_W-1:0] result;
  logic [4*DIGITS-1:0] bcd;
  logic [7*DIGITS-1:0] seg;
  int compared = 0, mismatched = 0;
  typedef struct {
    logic [1:0]          m;
    int                  n;
    logic [ACC_W-1:0]    res;
    logic                ovf;
    logic [4*DIGITS-1:0] bcd;
    int                  lat;
  } vec_t;
  vec_t tv [NV];
  series_accumulator #(.N_W(N_W), .ACC_W(ACC_W), .DIGITS(DIGITS), .BLANK_LZ(1)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .n_in(n_in),
    .busy(busy), .done(done), .overflow(overflow), .result(result), .bcd(bcd), .seg(seg)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask
  function automatic logic [7*DIGITS-1:0] seg_of(input logic [4*DIGITS-1:0] b, input logic o);
    int top = 0;
    logic [7*DIGITS-1:0] s;
    for (int i = 0; i < DIGITS; i++) if (b[4*i +: 4] != 4'd0) top = i;
    for (int i = 0; i < DIGITS; i++)
      s[7*i +: 7] = o ? 7'b1111110 : (i > top ? 7'b1111111 : CODE[b[4*i +: 4]]);
    return s;
  endfunction
  // Busy cycles = negedges after the start edge with done still low.
  task automatic run(input logic [1:0] m, input int n, output int lat, output bit ok, output int gaps);
    @(negedge clk);
    start = 1'b1;
    mode = m;
    n_in = n[N_W-1:0];
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    ok = 1'b0;
    gaps = 0;
    while (lat < 1000) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (!busy) gaps++;
      lat++;
    end
  endtask
  initial begin
    int lat, gaps, dones;
    bit ok;
    logic [ACC_W-1:0] seen_res;
    tv[0]  = '{2'd0, 10,  20'd55,     1'b0, 28'h0000055, 30};
    tv[1]  = '{2'd1, 5,   20'd55,     1'b0, 28'h0000055, 25};
    tv[2]  = '{2'd2, 12,  20'd144,    1'b0, 28'h0000144, 32};
    tv[3]  = '{2'd0, 255, 20'd32640,  1'b0, 28'h0032640, 275};
    tv[4]  = '{2'd3, 9,   20'd362880, 1'b0, 28'h0362880, 29};
    tv[5]  = '{2'd3, 10,  20'hFFFFF,  1'b1, 28'h1048575, 30};
    tv[6]  = '{2'd0, 3,   20'd6,      1'b0, 28'h0000006, 23};
    tv[7]  = '{2'd0, 0,   20'd0,      1'b0, 28'h0000000, 20};
    tv[8]  = '{2'd3, 0,   20'd1,      1'b0, 28'h0000001, 20};
    tv[9]  = '{2'd1, 255, 20'hFFFFF,  1'b1, 28'h1048575, 167};
    tv[10] = '{2'd2, 255, 20'd65025,  1'b0, 28'h0065025, 275};
    tv[11] = '{2'd3, 1,   20'd1,      1'b0, 28'h0000001, 21};
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_bcd", 64'(bcd), 64'd0);
    chk("reset_seg", 64'(seg), 64'(seg_of('0, 1'b0)));
    rst = 1'b0;
    for (int i = 0; i < NV; i++) begin
      run(tv[i].m, tv[i].n, lat, ok, gaps);
      chk($sformatf("v%0d_done_seen", i), 64'(ok), 64'd1);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(tv[i].lat));
      chk($sformatf("v%0d_busy_gaps", i), 64'(gaps), 64'd0);
      chk($sformatf("v%0d_busy_in_done", i), 64'(busy), 64'd0);
      chk($sformatf("v%0d_result", i), 64'(result), 64'(tv[i].res));
      chk($sformatf("v%0d_overflow", i), 64'(overflow), 64'(tv[i].ovf));
      chk($sformatf("v%0d_bcd", i), 64'(bcd), 64'(tv[i].bcd));
      chk($sformatf("v%0d_seg", i), 64'(seg), 64'(seg_of(tv[i].bcd, tv[i].ovf)));
      @(negedge clk);
      chk($sformatf("v%0d_done_width", i), 64'(done), 64'd0);
      chk($sformatf("v%0d_result_hold", i), 64'(result), 64'(tv[i].res));
    end
    // Inputs churn while busy; only the originally latched run may complete.
    @(negedge clk);
    start = 1'b1;
    mode = 2'd1;
    n_in = 8'd5;
    @(posedge clk);
    #1;
    dones = 0;
    seen_res = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        seen_res = result;
      end
      start = busy ? 1'($urandom) : 1'b0;
      mode = 2'($urandom);
      n_in = N_W'($urandom);
    end
    start = 1'b0;
    chk("churn_done_count", 64'(dones), 64'd1);
    chk("churn_result", 64'(seen_res), 64'd55);
    // Asynchronous reset in the middle of a long run.
    @(negedge clk);
    start = 1'b1;
    mode = 2'd0;
    n_in = 8'd200;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (50) @(negedge clk);
    chk("midrun_busy_before", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrun_busy", 64'(busy), 64'd0);
    chk("midrun_result", 64'(result), 64'd0);
    chk("midrun_bcd", 64'(bcd), 64'd0);
    dones = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dones++;
    end
    rst = 1'b0;
    repeat (250) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("midrun_no_done", 64'(dones), 64'd0);
    run(2'd0, 4, lat, ok, gaps);
    chk("after_reset_done_seen", 64'(ok), 64'd1);
    chk("after_reset_latency", 64'(lat), 64'd24);
    chk("after_reset_result", 64'(result), 64'd10);
    chk("after_reset_seg", 64'(seg), 64'(seg_of(28'h10, 1'b0)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
